int_req_ctrl: RTL and testbench
===============================

// Module: int_req_ctrl
// PURPOSE
//  Interrupt request controller sitting directly upstream of the i7_6700k core.
//  Synchronises three raw break buttons, latches rising edges as pending requests,
//  arbitrates by fixed priority with nesting, and drives the core's interrupt/vector
//  handshake. Exposes pending (ir_sig) and in-service (iw) bits for board LEDs.
// PARAMETERS
//  VEC_W       32             width of int_vec
//  VEC_BASE    32'h0000_1000  handler address for source 0
//  VEC_STRIDE  32'h0000_0010  address step per source (vector = BASE + idx*STRIDE)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  RST        in   1      asynchronous, active-high reset
//  break_in   in   3      raw, asynchronous button inputs; bit0 = highest priority
//  int_en     in   1      global interrupt enable from core status
//  cpu_ack    in   1      1-cycle pulse: core has taken the interrupt on int_vec
//  cpu_eret   in   1      1-cycle pulse: core returns from current handler
//  interrupt  out  1      registered request to core
//  int_vec    out  VEC_W  registered handler address, valid while interrupt=1
//  ir_sig     out  3      pending bits
//  iw         out  3      in-service bits
// BEHAVIOUR
//  - Reset: interrupt=0, int_vec=0, ir_sig=0, iw=0; sync FFs and edge-history regs=0.
//    A button held high across reset release therefore yields exactly one pending set.
//  - Sync: 2-FF synchroniser per bit, then edge = s2 & ~prev. Raw rise captured at
//    edge k -> s2 high at k+1 -> pending set at k+2 -> interrupt=1 at k+3 (if eligible).
//  - Eligible source: lowest index i with ir_sig[i]=1 whose index is strictly lower
//    than the lowest set bit of iw (any i if iw==0); requires int_en=1.
//  - FSM (2 states): IDLE: interrupt=0; eligible source exists -> REQ, register
//    interrupt=1 and int_vec=VEC_BASE+i*VEC_STRIDE (arithmetic truncated to VEC_W).
//    REQ: re-arbitrate every cycle; a newly eligible higher-priority source updates
//    int_vec next cycle. No eligible source (int_en dropped) -> IDLE, interrupt=0.
//    cpu_ack in REQ -> ir_sig[i]=0, iw[i]=1 for the i currently on int_vec; -> IDLE,
//    interrupt=0 next cycle.
//  - cpu_ack while in IDLE is ignored (no state change).
//  - cpu_eret clears the lowest set bit of iw; eret with iw==0 is ignored.
//  - ack+eret same cycle: eret clears the lowest pre-cycle iw bit, ack sets the acked
//    bit; both applied. Re-arbitration uses the updated state on the next cycle.
//  - New edge on source i in the same cycle as its ack: ir_sig[i] remains 1 (set wins),
//    iw[i] still set. Repeated edges while pending collapse to one request.
//  - Pending is never lost through int_en=0; it waits until enabled.
//  - Reset mid-handshake: everything returns to reset values immediately; no ack owed.
// CONFIGURATION
//  IRQ_MASK_EN defined: adds input port irq_mask [2:0] (after cpu_eret); source i with
//    irq_mask[i]=1 still latches into ir_sig but is never eligible; unmasking an
//    already-pending source makes it eligible on the following cycle.
//  IRQ_MASK_EN undefined: no irq_mask port; all sources unmaskable.
// TESTING
//  1. RST=1 for 3 cycles, release -> all outputs 0; no interrupt for 10 cycles idle.
//  2. int_en=1, pulse break_in[1] at edge k -> ir_sig=3'b010 at k+2, interrupt=1 and
//     int_vec=32'h1010 at k+3; cpu_ack -> iw=3'b010, ir_sig=0, interrupt=0 next cycle.
//  3. iw=3'b010 in service, press break_in[2] -> ir_sig=3'b100, interrupt stays 0;
//     press break_in[0] -> interrupt=1, int_vec=32'h1000 (nesting); ack -> iw=3'b011.
//  4. All three pressed same cycle -> int_vec=32'h1000; after ack/eret chain vectors
//     1000, 1010, 1020 in order; eret with iw==0 leaves state unchanged.
//  5. int_en=0, press break_in[2] -> ir_sig=3'b100, interrupt=0; int_en=1 ->
//     interrupt=1 next cycle; assert RST while interrupt=1 -> all outputs 0 at once.
//  6. IRQ_MASK_EN: irq_mask=3'b001, press break_in[0] -> ir_sig=3'b001, interrupt=0;
//     irq_mask=0 -> interrupt=1, int_vec=32'h1000 next cycle.

Source files
------------

// File: rtl/int_req_ctrl.sv
// Interrupt request controller: button sync/edge capture, fixed-priority nested arbitration, core handshake.
// Optional IRQ_MASK_EN adds an irq_mask input that blocks eligibility without blocking latching.
module int_req_ctrl #(
    parameter int unsigned      VEC_W      = 32,
    parameter logic [VEC_W-1:0] VEC_BASE   = 32'h0000_1000,
    parameter logic [VEC_W-1:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [2:0]       break_in,
    input  logic             int_en,
    input  logic             cpu_ack,
    input  logic             cpu_eret,
`ifdef IRQ_MASK_EN
    input  logic [2:0]       irq_mask,
`endif
    output logic             interrupt,
    output logic [VEC_W-1:0] int_vec,
    output logic [2:0]       ir_sig,
    output logic [2:0]       iw
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t           state, state_next;
    logic [2:0]       sync1, sync2, prev, rise;
    logic [2:0]       mask_eff, iw_low, allowed, cand, ack_clr;
    logic [1:0]       cur_idx, idx_next, sel_idx;
    logic [VEC_W-1:0] vec_next, vec_calc;
    logic             eligible, ack_take;

`ifdef IRQ_MASK_EN
    assign mask_eff = irq_mask;
`else
    assign mask_eff = '0;
`endif

    assign rise = sync2 & ~prev;

    // Only sources strictly above the highest-priority in-service one may nest.
    assign iw_low  = iw & (~iw + 3'd1);
    assign allowed = (iw == '0) ? '1 : (iw_low - 3'd1);
    assign cand    = ir_sig & ~mask_eff & allowed & {3{int_en}};
    assign eligible = |cand;

    always_comb begin
        sel_idx = 2'd0;
        if (cand[0])      sel_idx = 2'd0;
        else if (cand[1]) sel_idx = 2'd1;
        else if (cand[2]) sel_idx = 2'd2;
    end

    assign vec_calc = VEC_BASE + VEC_STRIDE * VEC_W'(sel_idx);

    always_comb begin
        state_next = state;
        vec_next   = int_vec;
        idx_next   = cur_idx;
        ack_take   = 1'b0;
        case (state)
            IDLE: begin
                if (eligible) begin
                    state_next = REQ;
                    vec_next   = vec_calc;
                    idx_next   = sel_idx;
                end
            end
            REQ: begin
                if (cpu_ack) begin
                    ack_take   = 1'b1;
                    state_next = IDLE;
                end else if (eligible) begin
                    vec_next = vec_calc;
                    idx_next = sel_idx;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ack_clr   = ack_take ? (3'b001 << cur_idx) : '0;
    assign interrupt = (state == REQ);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            ir_sig  <= '0;
            iw      <= '0;
            int_vec <= '0;
            cur_idx <= '0;
        end else begin
            state   <= state_next;
            sync1   <= break_in;
            sync2   <= sync1;
            prev    <= sync2;
            // A new edge in the ack cycle wins over the ack clear.
            ir_sig  <= (ir_sig & ~ack_clr) | rise;
            iw      <= (iw & ~(cpu_eret ? iw_low : 3'b000)) | ack_clr;
            int_vec <= vec_next;
            cur_idx <= idx_next;
        end
    end

endmodule

// File: tb/tb_int_req_ctrl.sv
// Directed self-checking bench for int_req_ctrl.
module tb_int_req_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic [2:0]  break_in;
    logic        int_en, cpu_ack, cpu_eret;
`ifdef IRQ_MASK_EN
    logic [2:0]  irq_mask;
`endif
    logic        interrupt;
    logic [31:0] int_vec;
    logic [2:0]  ir_sig, iw;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    int_req_ctrl #(.VEC_W(32), .VEC_BASE(32'h0000_1000), .VEC_STRIDE(32'h0000_0010)) dut (
        .clk(clk), .RST(RST), .break_in(break_in), .int_en(int_en),
        .cpu_ack(cpu_ack), .cpu_eret(cpu_eret),
`ifdef IRQ_MASK_EN
        .irq_mask(irq_mask),
`endif
        .interrupt(interrupt), .int_vec(int_vec), .ir_sig(ir_sig), .iw(iw)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raw press seen at the next edge k; returns just after edge k+2 (ir_sig set).
    task automatic press(input logic [2:0] b);
        break_in = b;
        tick();
        break_in = '0;
        tick();
        tick();
    endtask

    task automatic ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    task automatic eret();
        cpu_eret = 1'b1;
        tick();
        cpu_eret = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic i, input logic [31:0] v,
                             input logic [2:0] p, input logic [2:0] s);
        check({tag, "_int"}, 32'(interrupt), 32'(i));
        check({tag, "_vec"}, int_vec, v);
        check({tag, "_ir"},  32'(ir_sig), 32'(p));
        check({tag, "_iw"},  32'(iw), 32'(s));
    endtask

    initial begin
        RST = 1'b1; break_in = '0; int_en = 1'b0; cpu_ack = 1'b0; cpu_eret = 1'b0;
`ifdef IRQ_MASK_EN
        irq_mask = '0;
`endif
        // 1: reset and idle
        repeat (3) tick();
        check_all("rst", 1'b0, 32'h0, 3'b000, 3'b000);
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_int", 32'(interrupt), 32'h0);
        end

        // 2: single request on source 1
        int_en = 1'b1;
        press(3'b010);
        check("t2_pend", 32'(ir_sig), 32'h2);
        check("t2_nointyet", 32'(interrupt), 32'h0);
        tick();
        check("t2_int", 32'(interrupt), 32'h1);
        check("t2_vec", int_vec, 32'h1010);
        ack();
        check_all("t2_ack", 1'b0, 32'h1010, 3'b000, 3'b010);

        // 3: lower priority waits, higher priority nests
        press(3'b100);
        tick();
        check("t3_pend2", 32'(ir_sig), 32'h4);
        tick();
        check("t3_blocked", 32'(interrupt), 32'h0);
        press(3'b001);
        tick();
        check_all("t3_nest", 1'b1, 32'h1000, 3'b101, 3'b010);
        ack();
        check_all("t3_ack", 1'b0, 32'h1000, 3'b100, 3'b011);
        tick();
        check("t3_still0", 32'(interrupt), 32'h0);
        eret();
        check("t3_eret1", 32'(iw), 32'h2);
        eret();
        check("t3_eret2", 32'(iw), 32'h0);
        tick();
        check("t3_src2_int", 32'(interrupt), 32'h1);
        check("t3_src2_vec", int_vec, 32'h1020);
        ack();
        eret();
        check_all("t3_clean", 1'b0, 32'h1020, 3'b000, 3'b000);

        // 4: simultaneous press, ordered service chain
        press(3'b111);
        check("t4_pend", 32'(ir_sig), 32'h7);
        tick();
        check("t4_vec0", int_vec, 32'h1000);
        ack();
        check_all("t4_ack0", 1'b0, 32'h1000, 3'b110, 3'b001);
        eret();
        tick();
        check("t4_vec1", int_vec, 32'h1010);
        check("t4_int1", 32'(interrupt), 32'h1);
        ack();
        eret();
        tick();
        check("t4_vec2", int_vec, 32'h1020);
        ack();
        eret();
        check_all("t4_done", 1'b0, 32'h1020, 3'b000, 3'b000);
        eret();
        check_all("t4_eret0", 1'b0, 32'h1020, 3'b000, 3'b000);
        ack();
        check_all("t4_ackidle", 1'b0, 32'h1020, 3'b000, 3'b000);

        // 5: pending held while disabled, async reset mid-request
        int_en = 1'b0;
        press(3'b100);
        check("t5_pend", 32'(ir_sig), 32'h4);
        tick();
        tick();
        check("t5_dis", 32'(interrupt), 32'h0);
        int_en = 1'b1;
        tick();
        check("t5_en_int", 32'(interrupt), 32'h1);
        check("t5_en_vec", int_vec, 32'h1020);
        #2 RST = 1'b1;
        #1;
        check_all("t5_async", 1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        RST = 1'b0;
        tick();
        tick();
        check_all("t5_post", 1'b0, 32'h0, 3'b000, 3'b000);

`ifdef IRQ_MASK_EN
        // 6: masked source latches but waits
        irq_mask = 3'b001;
        press(3'b001);
        check("t6_pend", 32'(ir_sig), 32'h1);
        tick();
        tick();
        check("t6_masked", 32'(interrupt), 32'h0);
        irq_mask = '0;
        tick();
        check("t6_int", 32'(interrupt), 32'h1);
        check("t6_vec", int_vec, 32'h1000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
